// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the router packet source and its payload buffer.
//   Holds the header field widths, the default maximum payload length, the
//   buffer geometry, the packet-source state encoding and a helper that
//   builds the header byte.
//   No ports (package).

package router_pkg;

  localparam int HDR_ADDR_W      = 2;
  localparam int HDR_LEN_W       = 6;
  localparam int DATA_W          = 8;
  localparam int MAX_LEN_DEFAULT = 63;

  // The buffer is addressed by the same 6-bit index that counts payload bytes.
  localparam int BUF_DEPTH = 64;
  localparam int BUF_AW    = 6;

  // Destination code 3 does not exist on the router.
  localparam logic [HDR_ADDR_W-1:0] DEST_INVALID = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    CHECK
  } state_e;

  // Header byte as the router expects it: length in the upper six bits,
  // destination in the lower two.
  function automatic logic [DATA_W-1:0] hdr_byte(input logic [HDR_LEN_W-1:0]  len,
                                                  input logic [HDR_ADDR_W-1:0] dest);
    return {len, dest};
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// router_pkt_buf
//   64x8 payload buffer for the packet source. One synchronous write port
//   fills it while the payload is loaded; one combinational read port lets
//   the packet source fetch the next byte to put on the router bus.
//   The storage is deliberately not reset: every byte is written before it
//   is read within a packet.
//
//   Ports:
//     clock_i     rising-edge clock
//     wr_en_i     write strobe
//     wr_addr_i   write index (0..63)
//     wr_data_i   byte to store
//     rd_addr_i   read index (0..63)
//     rd_data_o   byte at rd_addr_i, combinational

module router_pkt_buf
  import router_pkg::*;
(
  input  logic              clock_i,
  input  logic              wr_en_i,
  input  logic [BUF_AW-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [BUF_AW-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];

  // Store one payload byte per accepted source transfer.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Asynchronous read so the next payload byte is ready at the consuming edge.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/router_pkt_source.sv
// router_pkt_source
//   Builds one router packet per command: buffers len payload bytes from a
//   valid/ready source, then sends header, payload and parity to the router
//   while honouring its busy line, and finally watches the router error
//   line for ERR_WAIT cycles before reporting completion.
//
//   Ports:
//     clock, reset           rising-edge clock, synchronous active-high reset
//     cmd_valid/dest/len     packet request (dest 0..2, len 1..MAX_LEN)
//     cmd_ready              high only while idle
//     cmd_reject             one-cycle pulse for an illegal request
//     src_valid/src_data     payload byte stream
//     src_ready              high only while loading the payload
//     pkt_valid, data_out    router packet-valid and data_in
//     busy, error            router busy and parity-error lines
//     pkt_done               one-cycle pulse when a packet completes
//     pkt_err                error result of the last packet, held until the
//                            next accepted request
//
//   All outputs come straight from registers, so busy never reaches
//   data_out or pkt_valid combinationally.

module router_pkt_source
  import router_pkg::*;
#(
  parameter int MAX_LEN  = MAX_LEN_DEFAULT,
  parameter int ERR_WAIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [HDR_ADDR_W-1:0] cmd_dest,
  input  logic [HDR_LEN_W-1:0]  cmd_len,
  output logic                  cmd_ready,
  output logic                  cmd_reject,
  input  logic                  src_valid,
  input  logic [DATA_W-1:0]     src_data,
  output logic                  src_ready,
  output logic                  pkt_valid,
  output logic [DATA_W-1:0]     data_out,
  input  logic                  busy,
  input  logic                  error,
  output logic                  pkt_done,
  output logic                  pkt_err
);

  localparam int               CNT_W    = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ERR_WAIT - 1);

  state_e                state_q;
  logic [HDR_ADDR_W-1:0] dest_q;
  logic [HDR_LEN_W-1:0]  len_q;
  logic [BUF_AW-1:0]     wr_idx_q;
  logic [BUF_AW-1:0]     rd_idx_q;
  logic [DATA_W-1:0]     parity_q;
  logic [DATA_W-1:0]     data_out_q;
  logic [CNT_W-1:0]      chk_cnt_q;
  logic                  err_seen_q;
  logic                  cmd_ready_q;
  logic                  cmd_reject_q;
  logic                  src_ready_q;
  logic                  pkt_valid_q;
  logic                  pkt_done_q;
  logic                  pkt_err_q;

  logic                  src_take;
  logic                  cmd_illegal;
  logic                  last_load;
  logic                  last_pay;
  logic                  err_d;
  logic [DATA_W-1:0]     parity_d;
  logic [BUF_AW-1:0]     wr_idx_d;
  logic [BUF_AW-1:0]     rd_idx_d;
  logic [DATA_W-1:0]     buf_rd_data;

  // Handshake and bookkeeping helpers shared by the state machine below.
  // src_ready is only ever high in LOAD, so src_take also implies LOAD and
  // is safe to use directly as the buffer write strobe.
  assign src_take    = src_valid & src_ready_q;
  assign cmd_illegal = (cmd_len == '0) || (cmd_dest == DEST_INVALID) ||
                       (int'(cmd_len) > MAX_LEN);
  assign last_load   = (wr_idx_q == (len_q - HDR_LEN_W'(1)));
  assign last_pay    = (rd_idx_q == len_q);
  assign err_d       = err_seen_q | error;
  assign parity_d    = parity_q ^ src_data;
  assign wr_idx_d    = wr_idx_q + BUF_AW'(1);
  assign rd_idx_d    = rd_idx_q + BUF_AW'(1);

  router_pkt_buf u_buf (
    .clock_i   (clock),
    .wr_en_i   (src_take),
    .wr_addr_i (wr_idx_q),
    .wr_data_i (src_data),
    .rd_addr_i (rd_idx_q),
    .rd_data_o (buf_rd_data)
  );

  // Packet sequencer. Every output is a register updated here, so the
  // router sees stable values for the whole cycle. rd_idx_q always points
  // at the next payload byte to fetch; when it reaches len_q the byte on
  // the bus is the last one and the next consumption sends parity instead.
  // The header is folded into parity on the same edge that stores the last
  // payload byte, so it is counted exactly once regardless of busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      len_q        <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      parity_q     <= '0;
      data_out_q   <= '0;
      chk_cnt_q    <= '0;
      err_seen_q   <= 1'b0;
      cmd_ready_q  <= 1'b1;
      cmd_reject_q <= 1'b0;
      src_ready_q  <= 1'b0;
      pkt_valid_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      cmd_reject_q <= 1'b0;
      pkt_done_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            if (cmd_illegal) begin
              cmd_reject_q <= 1'b1;
            end else begin
              state_q     <= LOAD;
              dest_q      <= cmd_dest;
              len_q       <= cmd_len;
              wr_idx_q    <= '0;
              rd_idx_q    <= '0;
              parity_q    <= '0;
              pkt_err_q   <= 1'b0;
              cmd_ready_q <= 1'b0;
              src_ready_q <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (src_take) begin
            if (last_load) begin
              state_q     <= HEADER;
              src_ready_q <= 1'b0;
              pkt_valid_q <= 1'b1;
              data_out_q  <= hdr_byte(len_q, dest_q);
              parity_q    <= parity_d ^ hdr_byte(len_q, dest_q);
            end else begin
              parity_q <= parity_d;
              wr_idx_q <= wr_idx_d;
            end
          end
        end

        HEADER: begin
          if (!busy) begin
            state_q    <= PAYLOAD;
            data_out_q <= buf_rd_data;
            rd_idx_q   <= rd_idx_d;
          end
        end

        PAYLOAD: begin
          if (!busy) begin
            if (last_pay) begin
              state_q     <= PARITY;
              pkt_valid_q <= 1'b0;
              data_out_q  <= parity_q;
            end else begin
              data_out_q <= buf_rd_data;
              rd_idx_q   <= rd_idx_d;
            end
          end
        end

        PARITY: begin
          if (!busy) begin
            state_q    <= CHECK;
            data_out_q <= '0;
            chk_cnt_q  <= '0;
            err_seen_q <= 1'b0;
          end
        end

        CHECK: begin
          if (chk_cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            pkt_done_q  <= 1'b1;
            pkt_err_q   <= err_d;
            err_seen_q  <= 1'b0;
          end else begin
            chk_cnt_q  <= chk_cnt_q + CNT_W'(1);
            err_seen_q <= err_d;
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          src_ready_q <= 1'b0;
          pkt_valid_q <= 1'b0;
          data_out_q  <= '0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign cmd_reject = cmd_reject_q;
  assign src_ready  = src_ready_q;
  assign pkt_valid  = pkt_valid_q;
  assign data_out   = data_out_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_err    = pkt_err_q;

endmodule

// File: tb/tb_router_pkt_source.sv
// tb_router_pkt_source
//   Directed bench for router_pkt_source. Inputs are driven 1 time unit
//   after each rising edge and outputs are sampled at the same point, so
//   every sample reflects the registers loaded by the preceding edge.

module tb_router_pkt_source;

  localparam int ERR_WAIT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_dest;
  logic [5:0] cmd_len;
  logic       cmd_ready;
  logic       cmd_reject;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       busy;
  logic       error;
  logic       pkt_done;
  logic       pkt_err;

  int vectorCount = 0;
  int failCount   = 0;

  logic [7:0] pl [64];

  router_pkt_source #(
    .MAX_LEN  (63),
    .ERR_WAIT (ERR_WAIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_dest   (cmd_dest),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .cmd_reject (cmd_reject),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .pkt_valid  (pkt_valid),
    .data_out   (data_out),
    .busy       (busy),
    .error      (error),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // Hard time limit so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic cv, input logic [1:0] d, input logic [5:0] l,
                               input logic sv, input logic [7:0] sd, input logic b,
                               input logic e);
    cmd_valid = cv;
    cmd_dest  = d;
    cmd_len   = l;
    src_valid = sv;
    src_data  = sd;
    busy      = b;
    error     = e;
  endtask

  // Runs one complete packet from IDLE. Payload comes from pl[]; expHdr and
  // expPar are worked out by hand by the caller. While loading, an illegal
  // command is held on the command port to show it is ignored outside IDLE.
  task automatic sendPacket(input logic [1:0] dest, input logic [5:0] len,
                            input logic [7:0] expHdr, input logic [7:0] expPar,
                            input bit altValid, input int hdrBusy, input int errCycle);
    int idx;
    int cyc;
    checkOutput("idle_ready", 32'(cmd_ready), 32'h1);
    applyStimulus(1'b1, dest, len, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    cmd_dest = 2'd3;
    cmd_len  = 6'd0;
    checkOutput("load_src_ready", 32'(src_ready), 32'h1);
    checkOutput("load_cmd_ready", 32'(cmd_ready), 32'h0);
    checkOutput("accept_clears_err", 32'(pkt_err), 32'h0);
    idx = 0;
    cyc = 0;
    while (idx < int'(len) && cyc < 4 * int'(len) + 8) begin
      src_valid = altValid ? cyc[0] : 1'b1;
      src_data  = pl[idx];
      step();
      checkOutput("load_no_reject", 32'(cmd_reject), 32'h0);
      if (src_valid) idx++;
      cyc++;
    end
    cmd_valid = 1'b0;
    src_valid = 1'b0;
    checkOutput("load_count", 32'(idx), 32'(len));
    checkOutput("hdr_valid", 32'(pkt_valid), 32'h1);
    checkOutput("hdr_data", 32'(data_out), 32'(expHdr));
    checkOutput("hdr_src_ready", 32'(src_ready), 32'h0);
    busy = 1'b1;
    for (int b = 0; b < hdrBusy; b++) begin
      step();
      checkOutput("hdr_hold_valid", 32'(pkt_valid), 32'h1);
      checkOutput("hdr_hold_data", 32'(data_out), 32'(expHdr));
    end
    busy = 1'b0;
    step();
    for (int i = 0; i < int'(len); i++) begin
      checkOutput("pay_valid", 32'(pkt_valid), 32'h1);
      checkOutput("pay_data", 32'(data_out), 32'(pl[i]));
      step();
    end
    checkOutput("par_valid", 32'(pkt_valid), 32'h0);
    checkOutput("par_data", 32'(data_out), 32'(expPar));
    step();
    for (int c = 1; c <= ERR_WAIT; c++) begin
      checkOutput("chk_valid", 32'(pkt_valid), 32'h0);
      checkOutput("chk_data", 32'(data_out), 32'h0);
      checkOutput("chk_no_done", 32'(pkt_done), 32'h0);
      error = (c == errCycle);
      step();
    end
    error = 1'b0;
    checkOutput("done_pulse", 32'(pkt_done), 32'h1);
    checkOutput("done_err", 32'(pkt_err), 32'(errCycle != 0));
    checkOutput("done_ready", 32'(cmd_ready), 32'h1);
    step();
    checkOutput("done_clear", 32'(pkt_done), 32'h0);
    checkOutput("err_hold", 32'(pkt_err), 32'(errCycle != 0));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("rst_pkt_valid", 32'(pkt_valid), 32'h0);
    checkOutput("rst_data_out", 32'(data_out), 32'h0);
    checkOutput("rst_src_ready", 32'(src_ready), 32'h0);
    checkOutput("rst_cmd_reject", 32'(cmd_reject), 32'h0);
    checkOutput("rst_pkt_done", 32'(pkt_done), 32'h0);
    checkOutput("rst_pkt_err", 32'(pkt_err), 32'h0);
    reset = 1'b0;
    step();

    // dest=1 len=3: header {3,1}=0x0D, parity 0x0D^0x11^0x22^0x33 = 0x0D.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    sendPacket(2'd1, 6'd3, 8'h0D, 8'h0D, 1'b0, 0, 0);

    // dest=2 len=2 with busy on the header for 3 cycles:
    // header {2,2}=0x0A, parity 0x0A^0xA5^0x3C = 0x93.
    pl[0] = 8'hA5; pl[1] = 8'h3C;
    sendPacket(2'd2, 6'd2, 8'h0A, 8'h93, 1'b0, 3, 0);

    // Illegal commands: zero length, then destination 3.
    applyStimulus(1'b1, 2'd1, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("rej_len0_pulse", 32'(cmd_reject), 32'h1);
    checkOutput("rej_len0_ready", 32'(cmd_ready), 32'h1);
    checkOutput("rej_len0_src", 32'(src_ready), 32'h0);
    cmd_valid = 1'b0;
    step();
    checkOutput("rej_len0_clear", 32'(cmd_reject), 32'h0);
    applyStimulus(1'b1, 2'd3, 6'd5, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("rej_dest3_pulse", 32'(cmd_reject), 32'h1);
    checkOutput("rej_dest3_ready", 32'(cmd_ready), 32'h1);
    checkOutput("rej_dest3_valid", 32'(pkt_valid), 32'h0);
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("rej_idle_reject", 32'(cmd_reject), 32'h0);
      checkOutput("rej_idle_valid", 32'(pkt_valid), 32'h0);
      checkOutput("rej_idle_ready", 32'(cmd_ready), 32'h1);
    end

    // Maximum length with alternating src_valid. Bytes are 1..63, whose XOR
    // is 0, so parity equals the header {63,2}=0xFE.
    for (int i = 0; i < 63; i++) pl[i] = 8'(i + 1);
    sendPacket(2'd2, 6'd63, 8'hFE, 8'hFE, 1'b1, 0, 0);

    // Single byte with error in CHECK cycle 2: header {1,0}=0x04, parity 0x84.
    pl[0] = 8'h80;
    sendPacket(2'd0, 6'd1, 8'h04, 8'h84, 1'b0, 0, 2);

    // Next accepted command clears pkt_err (checked right after acceptance).
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    sendPacket(2'd1, 6'd3, 8'h0D, 8'h0D, 1'b0, 0, 0);

    // Reset while the second payload byte is on the bus.
    pl[0] = 8'h5A; pl[1] = 8'hC3; pl[2] = 8'h0F; pl[3] = 8'hF0;
    applyStimulus(1'b1, 2'd2, 6'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    cmd_valid = 1'b0;
    src_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      src_data = pl[k];
      step();
    end
    src_valid = 1'b0;
    step();
    step();
    checkOutput("mid_valid", 32'(pkt_valid), 32'h1);
    checkOutput("mid_data", 32'(data_out), 32'(pl[1]));
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("abort_valid", 32'(pkt_valid), 32'h0);
    checkOutput("abort_ready", 32'(cmd_ready), 32'h1);
    checkOutput("abort_data", 32'(data_out), 32'h0);
    checkOutput("abort_done", 32'(pkt_done), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      checkOutput("abort_no_done", 32'(pkt_done), 32'h0);
      checkOutput("abort_idle_valid", 32'(pkt_valid), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
